// File: rtl/dac_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dac_mode_scheduler
// Description : Owns the one-hot generator run enables of the DAC sample path.
//               Every mode change runs drain -> clear -> wait-ready -> run.
//               Muxes the active generator's batch to the DAC and returns a
//               2-bit status response to the PS side.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_mode_scheduler #(
    parameter int BATCH_WIDTH  = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int RDY_TIMEOUT  = 1024
) (
    input  logic                     dac_clk,
    input  logic                     dac_rstn,
    input  logic [1:0]               cmd_mode,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               gen_rdy,
    input  logic [3*BATCH_WIDTH-1:0] gen_batch,
    input  logic [2:0]               gen_valid,
    input  logic                     dac0_rdy,
    output logic                     run_shift_regs,
    output logic                     run_trig_wav,
    output logic                     run_pwl,
    output logic                     gen_clear,
    output logic [BATCH_WIDTH-1:0]   dac_batch,
    output logic                     valid_dac_batch,
    output logic [1:0]               active_mode,
    output logic [15:0]              underrun_cnt,
    output logic [1:0]               resp_out,
    output logic                     resp_valid,
    input  logic                     resp_rdy
);

    // One counter serves both the drain length and the ready timeout
    localparam int c_cnt_max = (RDY_TIMEOUT > DRAIN_CYCLES) ? RDY_TIMEOUT : DRAIN_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [1:0] c_resp_ok      = 2'b00;
    localparam logic [1:0] c_resp_halted  = 2'b01;
    localparam logic [1:0] c_resp_timeout = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_CLEAR    = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_RUN      = 3'd4
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_target;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2:0]             r_run;
    logic                   r_gen_clear;
    logic [1:0]             r_active;
    logic [1:0]             r_resp;
    logic                   r_resp_valid;
    logic [BATCH_WIDTH-1:0] r_batch;
    logic                   r_batch_valid;
    logic [15:0]            r_underrun;

    logic                   w_cmd_ready;
    logic                   w_accept;
    logic                   w_same;
    logic                   w_new_mode;
    logic                   w_leave_run;
    logic                   w_tgt_rdy;
    logic [2:0]             w_tgt_onehot;
    logic                   w_sel_valid;
    logic [BATCH_WIDTH-1:0] w_sel_batch;

    // Commands are taken only in a stable state with no response outstanding
    assign w_cmd_ready = dac_rstn && ((r_state == S_IDLE) || (r_state == S_RUN)) && !r_resp_valid;
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign w_same      = w_accept && (r_state == S_RUN) && (cmd_mode == r_active);
    assign w_new_mode  = w_accept && (cmd_mode != 2'd0) && !w_same;
    assign w_leave_run = w_accept && (r_state == S_RUN) && !w_same;

    // Target-generator ready and run-enable decode
    always_comb begin
        w_tgt_rdy    = 1'b0;
        w_tgt_onehot = 3'b000;
        case (r_target)
            2'd1:    begin w_tgt_rdy = gen_rdy[0]; w_tgt_onehot = 3'b001; end
            2'd2:    begin w_tgt_rdy = gen_rdy[1]; w_tgt_onehot = 3'b010; end
            2'd3:    begin w_tgt_rdy = gen_rdy[2]; w_tgt_onehot = 3'b100; end
            default: begin w_tgt_rdy = 1'b0;       w_tgt_onehot = 3'b000; end
        endcase
    end

    // Select the running generator's valid and batch slice
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_batch = gen_batch[0 +: BATCH_WIDTH];
        case (r_active)
            2'd1:    begin w_sel_valid = gen_valid[0]; w_sel_batch = gen_batch[0*BATCH_WIDTH +: BATCH_WIDTH]; end
            2'd2:    begin w_sel_valid = gen_valid[1]; w_sel_batch = gen_batch[1*BATCH_WIDTH +: BATCH_WIDTH]; end
            2'd3:    begin w_sel_valid = gen_valid[2]; w_sel_batch = gen_batch[2*BATCH_WIDTH +: BATCH_WIDTH]; end
            default: begin w_sel_valid = 1'b0;         w_sel_batch = gen_batch[0 +: BATCH_WIDTH]; end
        endcase
    end

    // Mode-switch sequencer with registered enables, clear pulse and response
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            r_state      <= S_IDLE;
            r_target     <= 2'd0;
            r_cnt        <= '0;
            r_run        <= 3'b000;
            r_gen_clear  <= 1'b0;
            r_active     <= 2'd0;
            r_resp       <= 2'b00;
            r_resp_valid <= 1'b0;
        end else begin
            r_gen_clear <= 1'b0;
            if (r_resp_valid && resp_rdy) begin
                r_resp_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (cmd_mode == 2'd0) begin
                            r_resp       <= c_resp_halted;
                            r_resp_valid <= 1'b1;
                        end else begin
                            // Nothing is running, so there is nothing to drain
                            r_target    <= cmd_mode;
                            r_gen_clear <= 1'b1;
                            r_state     <= S_CLEAR;
                        end
                    end
                end
                S_RUN: begin
                    if (w_same) begin
                        r_resp       <= c_resp_ok;
                        r_resp_valid <= 1'b1;
                    end else if (w_accept) begin
                        r_target <= cmd_mode;
                        r_run    <= 3'b000;
                        r_active <= 2'd0;
                        r_cnt    <= '0;
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == c_cnt_w'(DRAIN_CYCLES - 1)) begin
                        r_gen_clear <= 1'b1;
                        r_state     <= S_CLEAR;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_CLEAR: begin
                    r_cnt <= '0;
                    if (r_target == 2'd0) begin
                        r_resp       <= c_resp_halted;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    // Ready is checked first so it wins on the timeout cycle
                    if (w_tgt_rdy) begin
                        r_run        <= w_tgt_onehot;
                        r_active     <= r_target;
                        r_resp       <= c_resp_ok;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RUN;
                    end else if (r_cnt == c_cnt_w'(RDY_TIMEOUT - 1)) begin
                        r_resp       <= c_resp_timeout;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Batch forwarding to the DAC and underrun accounting
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            r_batch       <= '0;
            r_batch_valid <= 1'b0;
            r_underrun    <= 16'd0;
        end else begin
            r_batch_valid <= 1'b0;
            if (w_new_mode) begin
                r_underrun <= 16'd0;
            end else if ((r_state == S_RUN) && !w_leave_run && w_sel_valid) begin
                if (dac0_rdy) begin
                    r_batch       <= w_sel_batch;
                    r_batch_valid <= 1'b1;
                end else if (r_underrun != 16'hFFFF) begin
                    r_underrun <= r_underrun + 16'd1;
                end
            end
        end
    end

    assign cmd_ready       = w_cmd_ready;
    assign run_shift_regs  = r_run[0];
    assign run_trig_wav    = r_run[1];
    assign run_pwl         = r_run[2];
    assign gen_clear       = r_gen_clear;
    assign dac_batch       = r_batch;
    assign valid_dac_batch = r_batch_valid;
    assign active_mode     = r_active;
    assign underrun_cnt    = r_underrun;
    assign resp_out        = r_resp;
    assign resp_valid      = r_resp_valid;

endmodule
`default_nettype wire

// File: tb/tb_dac_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_mode_scheduler
// Description : Self-checking bench for dac_mode_scheduler. A timeline model
//               of each mode switch and a batch/underrun model are derived
//               from the scheduling rules; stimulus is randomised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_mode_scheduler;

    localparam int BW    = 16;
    localparam int DRAIN = 4;
    localparam int TMO   = 1024;

    logic            dac_clk = 1'b0;
    logic            dac_rstn;
    logic [1:0]      cmd_mode;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      gen_rdy;
    logic [3*BW-1:0] gen_batch;
    logic [2:0]      gen_valid;
    logic            dac0_rdy;
    logic            run_shift_regs, run_trig_wav, run_pwl, gen_clear;
    logic [BW-1:0]   dac_batch;
    logic            valid_dac_batch;
    logic [1:0]      active_mode;
    logic [15:0]     underrun_cnt;
    logic [1:0]      resp_out;
    logic            resp_valid;
    logic            resp_rdy;

    int              n_total = 0;
    int              n_bad   = 0;
    logic [1:0]      m_active;
    logic [BW-1:0]   m_batch;

    always #5 dac_clk = ~dac_clk;

    dac_mode_scheduler #(
        .BATCH_WIDTH (BW),
        .DRAIN_CYCLES(DRAIN),
        .RDY_TIMEOUT (TMO)
    ) dut (
        .dac_clk        (dac_clk),
        .dac_rstn       (dac_rstn),
        .cmd_mode       (cmd_mode),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .gen_rdy        (gen_rdy),
        .gen_batch      (gen_batch),
        .gen_valid      (gen_valid),
        .dac0_rdy       (dac0_rdy),
        .run_shift_regs (run_shift_regs),
        .run_trig_wav   (run_trig_wav),
        .run_pwl        (run_pwl),
        .gen_clear      (gen_clear),
        .dac_batch      (dac_batch),
        .valid_dac_batch(valid_dac_batch),
        .active_mode    (active_mode),
        .underrun_cnt   (underrun_cnt),
        .resp_out       (resp_out),
        .resp_valid     (resp_valid),
        .resp_rdy       (resp_rdy)
    );

    function automatic logic [2:0] onehot(input logic [1:0] m);
        case (m)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    // Present a command and wait (bounded) for it to be accepted
    task automatic issue_cmd(input logic [1:0] m);
        int w;
        w = 0;
        cmd_mode  = m;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        n_total++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cmd_accept_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, w);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_mode  = 2'($urandom);
    endtask

    task automatic consume_resp();
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
    endtask

    // Switch to mode m; d = cycles spent in WAIT_RDY before the target ready rises
    task automatic do_switch(input logic [1:0] m, input bit from_run, input int d);
        int k_clear, k_rdy, k_run, idx;
        logic [7:0] exp_v, act_v;
        logic [2:0] r0;
        idx     = int'(m) - 1;
        k_clear = from_run ? DRAIN + 1 : 1;
        k_rdy   = k_clear + 1 + d;
        k_run   = k_rdy + 1;
        r0      = 3'($urandom);
        r0[idx] = 1'b0;
        gen_rdy   = r0;
        gen_valid = 3'b000;
        issue_cmd(m);
        for (int k = 1; k <= k_run; k++) begin
            exp_v = {(k == k_clear), (k >= k_run) ? onehot(m) : 3'b000,
                     (k >= k_run) ? m : 2'd0, 1'b0, (k == k_run)};
            act_v = {gen_clear, run_pwl, run_trig_wav, run_shift_regs, active_mode,
                     valid_dac_batch, resp_valid};
            n_total++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL switch_m%0d_cyc%0d: {clr,run,act,vld,rv}=%b required %b", m, k, act_v, exp_v);
            end
            if (k == k_rdy) gen_rdy[idx] = 1'b1;
            if (k < k_run) tick();
        end
        n_total++;
        if (resp_out !== 2'b00) begin
            n_bad++;
            $display("FAIL switch_resp_m%0d: resp_out=%b required 00", m, resp_out);
        end
        consume_resp();
        m_active = m;
    endtask

    task automatic test_reset();
        dac_rstn  = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        gen_rdy   = 3'b000;
        gen_valid = 3'b000;
        gen_batch = '0;
        dac0_rdy  = 1'b1;
        resp_rdy  = 1'b0;
        m_active  = 2'd0;
        m_batch   = '0;
        #2;
        n_total++;
        if ({cmd_ready, run_pwl, run_trig_wav, run_shift_regs, gen_clear, valid_dac_batch,
             active_mode, resp_out, resp_valid} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: ready=%b run=%b%b%b clr=%b vld=%b act=%0d resp=%b rv=%b, required all 0",
                     cmd_ready, run_pwl, run_trig_wav, run_shift_regs, gen_clear, valid_dac_batch,
                     active_mode, resp_out, resp_valid);
        end
        n_total++;
        if ({dac_batch, underrun_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: dac_batch=%h underrun=%0d required 0", dac_batch, underrun_cnt);
        end
        tick();
        tick();
        dac_rstn = 1'b1;
        tick();
        n_total++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_idle_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_idle_halt();
        issue_cmd(2'd0);
        n_total++;
        if ({resp_valid, resp_out, gen_clear, cmd_ready} !== 5'b10100) begin
            n_bad++;
            $display("FAIL idle_halt: rv=%b resp=%b clr=%b ready=%b required 1 01 0 0",
                     resp_valid, resp_out, gen_clear, cmd_ready);
        end
        consume_resp();
    endtask

    task automatic test_start_from_idle();
        do_switch(2'd3, 1'b0, 4);
    endtask

    task automatic test_same_mode();
        gen_valid = 3'b000;
        issue_cmd(m_active);
        n_total++;
        if ({resp_valid, resp_out, gen_clear, run_pwl, run_trig_wav, run_shift_regs, active_mode} !==
            {1'b1, 2'b00, 1'b0, onehot(m_active), m_active}) begin
            n_bad++;
            $display("FAIL same_mode: rv=%b resp=%b clr=%b run=%b%b%b act=%0d required resp 00, run unchanged mode %0d",
                     resp_valid, resp_out, gen_clear, run_pwl, run_trig_wav, run_shift_regs, active_mode, m_active);
        end
        consume_resp();
    endtask

    task automatic test_switch();
        do_switch(2'd1, 1'b1, $urandom_range(0, 3));
        do_switch(2'd2, 1'b1, 0);
    endtask

    // Target never ready: abort after the full wait window
    task automatic test_timeout();
        int k, clears;
        logic runs_seen;
        clears    = 0;
        runs_seen = 1'b0;
        gen_rdy   = 3'b011;
        gen_valid = 3'b000;
        issue_cmd(2'd3);
        k = 1;
        while (!resp_valid && k < 1200) begin
            if (gen_clear) clears++;
            if (run_pwl || run_trig_wav || run_shift_regs) runs_seen = 1'b1;
            tick();
            k++;
        end
        n_total++;
        if (k !== DRAIN + 1 + TMO + 1) begin
            n_bad++;
            $display("FAIL timeout_latency: resp at cycle %0d required %0d", k, DRAIN + 1 + TMO + 1);
        end
        n_total++;
        if ({resp_out, active_mode, run_pwl, run_trig_wav, run_shift_regs, runs_seen} !== 8'b10_00_000_0) begin
            n_bad++;
            $display("FAIL timeout_state: resp=%b act=%0d run=%b%b%b runs_seen=%b required 10 0 000 0",
                     resp_out, active_mode, run_pwl, run_trig_wav, run_shift_regs, runs_seen);
        end
        n_total++;
        if (clears !== 1) begin
            n_bad++;
            $display("FAIL timeout_clear_pulses: %0d required 1", clears);
        end
        consume_resp();
        m_active = 2'd0;
    endtask

    // Ready arriving on the last wait cycle still enters RUN
    task automatic test_ready_on_timeout();
        do_switch(2'd1, 1'b0, TMO - 1);
    endtask

    task automatic test_halt();
        gen_valid = 3'b000;
        issue_cmd(2'd0);
        for (int k = 1; k <= DRAIN + 2; k++) begin
            n_total++;
            if ({gen_clear, run_pwl, run_trig_wav, run_shift_regs, active_mode, resp_valid} !==
                {(k == DRAIN + 1), 5'b0, (k == DRAIN + 2)}) begin
                n_bad++;
                $display("FAIL halt_cyc%0d: clr=%b run=%b%b%b act=%0d rv=%b", k, gen_clear,
                         run_pwl, run_trig_wav, run_shift_regs, active_mode, resp_valid);
            end
            if (k < DRAIN + 2) tick();
        end
        n_total++;
        if (resp_out !== 2'b01) begin
            n_bad++;
            $display("FAIL halt_resp: resp_out=%b required 01", resp_out);
        end
        consume_resp();
        m_active = 2'd0;
    endtask

    // Random batches into PWL mode with a 10-cycle DAC stall, then fully random traffic
    task automatic test_datapath();
        int exp_u;
        logic exp_v;
        do_switch(2'd3, m_active != 2'd0, $urandom_range(0, 3));
        exp_u = 0;
        for (int i = 0; i < 70; i++) begin
            gen_batch = {16'($urandom), 16'($urandom), 16'($urandom)};
            gen_valid = 3'($urandom);
            if (i < 30) begin
                gen_valid[2] = 1'b1;
                dac0_rdy     = !(i >= 10 && i < 20);
            end else begin
                dac0_rdy = 1'($urandom);
            end
            exp_v = gen_valid[2] && dac0_rdy;
            if (exp_v) m_batch = gen_batch[2*BW +: BW];
            if (gen_valid[2] && !dac0_rdy && exp_u < 65535) exp_u++;
            tick();
            n_total++;
            if (valid_dac_batch !== exp_v || dac_batch !== m_batch) begin
                n_bad++;
                $display("FAIL datapath_%0d: vld=%b data=%h required vld=%b data=%h",
                         i, valid_dac_batch, dac_batch, exp_v, m_batch);
            end
            if (i == 29) begin
                n_total++;
                if (underrun_cnt !== 16'd10) begin
                    n_bad++;
                    $display("FAIL underrun_stall: %0d required 10", underrun_cnt);
                end
            end
        end
        n_total++;
        if (underrun_cnt !== 16'(exp_u)) begin
            n_bad++;
            $display("FAIL underrun_random: %0d required %0d", underrun_cnt, exp_u);
        end
        gen_valid = 3'b000;
        dac0_rdy  = 1'b1;
    endtask

    task automatic test_resp_hold();
        int w;
        gen_valid = 3'b000;
        issue_cmd(2'd0);
        w = 0;
        while (!resp_valid && w < 20) begin
            tick();
            w++;
        end
        for (int k = 0; k < 8; k++) begin
            n_total++;
            if ({resp_valid, resp_out, cmd_ready} !== 4'b1010) begin
                n_bad++;
                $display("FAIL resp_hold_%0d: rv=%b resp=%b ready=%b required 1 01 0",
                         k, resp_valid, resp_out, cmd_ready);
            end
            cmd_valid = 1'b1;
            cmd_mode  = 2'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        resp_rdy  = 1'b1;
        tick();
        resp_rdy = 1'b0;
        n_total++;
        if ({resp_valid, cmd_ready, run_pwl, run_trig_wav, run_shift_regs} !== 5'b01000) begin
            n_bad++;
            $display("FAIL resp_release: rv=%b ready=%b run=%b%b%b required rv 0 ready 1 run 000",
                     resp_valid, cmd_ready, run_pwl, run_trig_wav, run_shift_regs);
        end
        m_active = 2'd0;
    endtask

    task automatic test_reset_mid();
        gen_rdy = 3'b000;
        issue_cmd(2'd2);
        tick();
        tick();
        tick();
        dac_rstn = 1'b0;
        #1;
        n_total++;
        if ({cmd_ready, run_pwl, run_trig_wav, run_shift_regs, gen_clear, valid_dac_batch,
             active_mode, resp_out, resp_valid, dac_batch, underrun_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: ready=%b run=%b%b%b clr=%b rv=%b batch=%h required all 0",
                     cmd_ready, run_pwl, run_trig_wav, run_shift_regs, gen_clear, resp_valid, dac_batch);
        end
        tick();
        tick();
        dac_rstn = 1'b1;
        gen_rdy  = 3'b111;
        m_batch  = '0;
        m_active = 2'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_total++;
            if ({resp_valid, run_pwl, run_trig_wav, run_shift_regs, gen_clear, cmd_ready} !== 6'b000001) begin
                n_bad++;
                $display("FAIL reset_mid_idle_%0d: rv=%b run=%b%b%b clr=%b ready=%b required idle, no resp",
                         k, resp_valid, run_pwl, run_trig_wav, run_shift_regs, gen_clear, cmd_ready);
            end
        end
    endtask

    // Random command sequence; the model tracks only which mode should be running
    task automatic test_back_to_back();
        logic [1:0] m;
        for (int i = 0; i < 10; i++) begin
            m = 2'($urandom);
            if (m == 2'd0 && m_active == 2'd0)       test_idle_halt();
            else if (m == 2'd0)                      test_halt();
            else if (m == m_active)                  test_same_mode();
            else do_switch(m, m_active != 2'd0, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_halt();
        test_start_from_idle();
        test_same_mode();
        test_switch();
        test_timeout();
        test_ready_on_timeout();
        test_halt();
        test_datapath();
        test_resp_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
